core_ifetch_pf: RTL and testbench

CORE_IFETCH_PF -- requirements
Module: core_ifetch_pf

---
 rtl/core_ifetch_pf.sv | 125 ++++++++++++
 tb/tb_core_ifetch_pf.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_ifetch_pf.sv
// Instruction prefetcher: issues in-order AXI reads into a small FIFO under a credit limit,
// and on a redirect flushes the FIFO and drops the data of reads that are still in flight.
module core_ifetch_pf #(
  parameter int unsigned           AXI_AWIDTH = 32,
  parameter int unsigned           AXI_DWIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 4,
  parameter logic [AXI_AWIDTH-1:0] RESET_PC   = AXI_AWIDTH'(32'h0000_0000)
) (
  input  logic                  CLK,
  input  logic                  RST,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [31:0]           INSTRUCTION,
  output logic [AXI_AWIDTH-1:0] INSTR_PC,
  output logic                  INSTR_ERR,
  input  logic                  REDIRECT,
  input  logic [AXI_AWIDTH-1:0] REDIRECT_PC
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AXI_AWIDTH-1:0] fpc_q, fpc_d, rpc_q, rpc_d, araddr_q, araddr_d, redir_pc;
  logic [CW-1:0]         out_cnt_q, out_cnt_d, disc_cnt_q, disc_cnt_d, count_q, count_d;
  logic [CW:0]           credit_sum;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                  arvalid_q, arvalid_d, stale_q, stale_d, rready_q, valid_q;
  logic                  ar_hs, r_hs, ar_hold, push, pop;

  logic [31:0]           data_q [FIFO_DEPTH];
  logic [AXI_AWIDTH-1:0] pc_q   [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] err_q;

  // Next-state for pointers, counters and the AR channel
  always_comb begin
    ar_hs      = arvalid_q & AXI_ARREADY;
    r_hs       = AXI_RVALID & rready_q;
    ar_hold    = arvalid_q & ~AXI_ARREADY;
    pop        = valid_q & INSTR_READY;
    push       = r_hs & (disc_cnt_q == '0) & ~REDIRECT;
    redir_pc   = REDIRECT_PC & ~AXI_AWIDTH'(3);

    out_cnt_d  = out_cnt_q + CW'(ar_hs) - CW'(r_hs);
    disc_cnt_d = disc_cnt_q + CW'(ar_hs & stale_q) - CW'(r_hs & (disc_cnt_q != '0));
    stale_d    = stale_q & ~ar_hs;
    fpc_d      = (ar_hs & ~stale_q) ? fpc_q + AXI_AWIDTH'(4) : fpc_q;
    rpc_d      = push ? rpc_q + AXI_AWIDTH'(4) : rpc_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);

    // A held AR keeps its old address; if still unaccepted it becomes stale
    if (REDIRECT) begin
      fpc_d      = redir_pc;
      rpc_d      = redir_pc;
      disc_cnt_d = out_cnt_d;
      stale_d    = ar_hold;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end

    credit_sum = {1'b0, count_d} + {1'b0, out_cnt_d};
    arvalid_d  = ar_hold | (credit_sum < (CW+1)'(FIFO_DEPTH));
    araddr_d   = ar_hold ? araddr_q : fpc_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc_q      <= RESET_PC;
      rpc_q      <= RESET_PC;
      araddr_q   <= RESET_PC;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      arvalid_q  <= 1'b0;
      stale_q    <= 1'b0;
      rready_q   <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= '0;
    end else begin
      fpc_q      <= fpc_d;
      rpc_q      <= rpc_d;
      araddr_q   <= araddr_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      arvalid_q  <= arvalid_d;
      stale_q    <= stale_d;
      rready_q   <= 1'b1;
      valid_q    <= (count_d != '0);
      if (push) begin
        err_q[wr_ptr_q] <= (AXI_RRESP != 2'b00);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count/valid
  always_ff @(posedge CLK) begin
    if (push) begin
      data_q[wr_ptr_q] <= 32'(AXI_RDATA);
      pc_q[wr_ptr_q]   <= rpc_q;
    end
  end

  assign AXI_ARADDR  = araddr_q;
  assign AXI_ARVALID = arvalid_q;
  assign AXI_RREADY  = rready_q;
  assign INSTR_VALID = valid_q;
  assign INSTRUCTION = data_q[rd_ptr_q];
  assign INSTR_PC    = pc_q[rd_ptr_q];
  assign INSTR_ERR   = valid_q & err_q[rd_ptr_q];

endmodule

// File: tb/tb_core_ifetch_pf.sv
// Bench for core_ifetch_pf: in-order AXI slave, epoch-tagged fetch-stream model and directed scenarios.
module tb_core_ifetch_pf;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] AXI_ARADDR;
  logic        AXI_ARVALID;
  logic        AXI_ARREADY = 1'b1;
  logic [31:0] AXI_RDATA   = '0;
  logic [1:0]  AXI_RRESP   = '0;
  logic        AXI_RVALID  = 1'b0;
  logic        AXI_RREADY;
  logic        INSTR_VALID;
  logic        INSTR_READY = 1'b1;
  logic [31:0] INSTRUCTION;
  logic [31:0] INSTR_PC;
  logic        INSTR_ERR;
  logic        REDIRECT    = 1'b0;
  logic [31:0] REDIRECT_PC = '0;

  core_ifetch_pf #(
    .AXI_AWIDTH(32), .AXI_DWIDTH(32), .FIFO_DEPTH(DEPTH), .RESET_PC(RPC)
  ) dut (
    .CLK(CLK), .RST(RST),
    .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
    .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
    .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .INSTRUCTION(INSTRUCTION),
    .INSTR_PC(INSTR_PC), .INSTR_ERR(INSTR_ERR),
    .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC)
  );

  initial forever #5 CLK = ~CLK;

  typedef struct packed { logic [31:0] tag; logic [31:0] addr; } beat_t;
  typedef struct packed { logic [31:0] data; logic [31:0] pc; logic err; } ent_t;

  beat_t       sq[$];
  ent_t        mq[$];
  logic [31:0] pop_pc[$];
  logic        pop_err[$];

  int n_cmp = 0, n_bad = 0;
  int cyc_n = 0, since_rel = 0, ar_cnt = 0, dropped = 0, dropped0 = 0;
  int first_ar = -1, first_iv = -1;
  logic [31:0] epoch = 0, launch_tag = 0, exp_fpc = RPC, held_addr = 0;
  logic        prev_hold = 1'b0;
  logic        rv_en = 1'b1;
  logic [31:0] err_addr = 32'hFFFF_FFFF;

  logic        s_arv, s_arr, s_rv, s_rr, s_iv, s_ir, s_rd;
  logic [31:0] s_ard, s_rdpc;
  beat_t       s_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a == err_addr) ? 2'b10 : 2'b00;
  endfunction

  // Slave + reference model: every AR carries the redirect epoch in which it was launched;
  // a beat becomes an instruction only if its epoch is still current and no redirect coincides.
  initial begin
    forever begin
      @(posedge CLK);
      cyc_n++;
      if (RST) begin
        sq.delete(); mq.delete();
        epoch = 0; launch_tag = 0; exp_fpc = RPC; prev_hold = 1'b0; since_rel = 0;
        #1;
        AXI_RVALID = 1'b0;
      end else begin
        since_rel++;
        s_arv = AXI_ARVALID; s_ard = AXI_ARADDR; s_arr = AXI_ARREADY;
        s_rv = AXI_RVALID; s_rr = AXI_RREADY; s_iv = INSTR_VALID; s_ir = INSTR_READY;
        s_rd = REDIRECT; s_rdpc = REDIRECT_PC;
        if (prev_hold) chk("ar_hold", {31'b0, s_arv, s_ard}, {31'b0, 1'b1, held_addr});
        if (s_arv && !prev_hold) launch_tag = epoch;
        if (s_arv && s_arr) begin
          ar_cnt++;
          if (launch_tag == epoch) begin
            chk("araddr", s_ard, exp_fpc);
            exp_fpc = exp_fpc + 32'd4;
          end
          sq.push_back('{tag: launch_tag, addr: s_ard});
        end
        prev_hold = s_arv && !s_arr;
        held_addr = s_ard;
        if (s_iv && s_ir) begin
          pop_pc.push_back(INSTR_PC);
          pop_err.push_back(INSTR_ERR);
          if (mq.size() > 0) void'(mq.pop_front());
        end
        if (s_rv && s_rr && sq.size() > 0) begin
          s_b = sq.pop_front();
          if (s_b.tag == epoch && !s_rd)
            mq.push_back('{data: word_of(s_b.addr), pc: s_b.addr, err: resp_of(s_b.addr) != 2'b00});
          else
            dropped++;
        end
        if (s_rd) begin
          mq.delete();
          epoch = epoch + 32'd1;
          exp_fpc = {s_rdpc[31:2], 2'b00};
        end
        #1;
        if (rv_en && sq.size() > 0) begin
          AXI_RVALID = 1'b1;
          AXI_RDATA  = word_of(sq[0].addr);
          AXI_RRESP  = resp_of(sq[0].addr);
        end else begin
          AXI_RVALID = 1'b0;
          AXI_RDATA  = '0;
          AXI_RRESP  = '0;
        end
      end
    end
  end

  // Compare process: DUT head entry and flow invariants against the model, every cycle
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        chk("rst_arvalid", AXI_ARVALID, 1'b0);
        chk("rst_rready", AXI_RREADY, 1'b0);
        chk("rst_ivalid", INSTR_VALID, 1'b0);
        chk("rst_ierr", INSTR_ERR, 1'b0);
        chk("rst_araddr", AXI_ARADDR, RPC);
      end else begin
        chk("instr_valid", INSTR_VALID, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("instr_pc", INSTR_PC, mq[0].pc);
          chk("instruction", INSTRUCTION, mq[0].data);
          chk("instr_err", INSTR_ERR, mq[0].err);
        end
        chk("credit", (mq.size() + sq.size() + int'(AXI_ARVALID)) <= DEPTH, 1'b1);
        if (since_rel > 0) chk("rready", AXI_RREADY, 1'b1);
        if (AXI_ARVALID && AXI_ARREADY && first_ar < 0) first_ar = cyc_n;
        if (INSTR_VALID && first_iv < 0) first_iv = cyc_n;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #2;
    end
  endtask

  task automatic wait_pops(input int n, input int budget);
    for (int k = 0; k < budget && pop_pc.size() < n; k++) cyc(1);
    chk("pop_timeout", pop_pc.size() >= n, 1'b1);
  endtask

  task automatic start(input logic ir);
    RST = 1'b1; INSTR_READY = ir; AXI_ARREADY = 1'b1; rv_en = 1'b1; REDIRECT = 1'b0;
    cyc(2);
    ar_cnt = 0; first_ar = -1; first_iv = -1;
    pop_pc.delete(); pop_err.delete();
    RST = 1'b0;
  endtask

  initial begin
    // Stream: PCs 0,4,8,... and two-cycle AR-to-instruction latency
    start(1'b1);
    wait_pops(6, 40);
    chk("s1_latency", 64'(first_iv - first_ar), 64'd2);
    for (int i = 0; i < 5; i++) chk("s1_pc", pop_pc[i], 32'(i * 4));

    // Backpressure: four ARs fill the credit, one pop buys exactly one more
    start(1'b0);
    cyc(12);
    chk("s2_ar4", 64'(ar_cnt), 64'd4);
    chk("s2_arvalid_lo", AXI_ARVALID, 1'b0);
    chk("s2_ivalid", INSTR_VALID, 1'b1);
    INSTR_READY = 1'b1;
    cyc(1);
    INSTR_READY = 1'b0;
    cyc(8);
    chk("s2_ar5", 64'(ar_cnt), 64'd5);
    chk("s2_arvalid_lo2", AXI_ARVALID, 1'b0);

    // Redirect with three reads outstanding (one entry buffered)
    start(1'b0);
    for (int k = 0; k < 10 && ar_cnt < 1; k++) cyc(1);
    rv_en = 1'b0;
    for (int k = 0; k < 20 && AXI_ARVALID; k++) cyc(1);
    chk("s3_ar4", 64'(ar_cnt), 64'd4);
    chk("s3_ivalid_pre", INSTR_VALID, 1'b1);
    dropped0 = dropped;
    REDIRECT_PC = 32'h100; REDIRECT = 1'b1;
    cyc(1);
    REDIRECT = 1'b0;
    chk("s3_ivalid_flush", INSTR_VALID, 1'b0);
    chk("s3_arvalid", AXI_ARVALID, 1'b1);
    chk("s3_araddr", AXI_ARADDR, 32'h100);
    pop_pc.delete(); pop_err.delete();
    rv_en = 1'b1; INSTR_READY = 1'b1;
    wait_pops(1, 30);
    chk("s3_first_pc", pop_pc[0], 32'h100);
    chk("s3_dropped", 64'(dropped - dropped0), 64'd3);

    // Redirect while an AR to 0x8 is held
    start(1'b1);
    for (int k = 0; k < 20 && !(AXI_ARVALID && AXI_ARADDR == 32'h8); k++) cyc(1);
    AXI_ARREADY = 1'b0;
    cyc(1);
    REDIRECT_PC = 32'h203; REDIRECT = 1'b1;
    cyc(1);
    REDIRECT = 1'b0;
    pop_pc.delete(); pop_err.delete();
    dropped0 = dropped;
    chk("s4_hold_v", AXI_ARVALID, 1'b1);
    chk("s4_hold_a", AXI_ARADDR, 32'h8);
    cyc(2);
    chk("s4_hold_a2", AXI_ARADDR, 32'h8);
    AXI_ARREADY = 1'b1;
    cyc(1);
    chk("s4_next_v", AXI_ARVALID, 1'b1);
    chk("s4_next_a", AXI_ARADDR, 32'h200);
    wait_pops(1, 30);
    chk("s4_first_pc", pop_pc[0], 32'h200);
    chk("s4_dropped", 64'(dropped - dropped0), 64'd1);

    // Error response on the 0x4 beat travels with that entry only
    err_addr = 32'h4;
    start(1'b1);
    wait_pops(3, 40);
    chk("s5_pc1", pop_pc[1], 32'h4);
    chk("s5_err0", pop_err[0], 1'b0);
    chk("s5_err1", pop_err[1], 1'b1);
    chk("s5_err2", pop_err[2], 1'b0);
    err_addr = 32'hFFFF_FFFF;

    // Reset with two entries buffered and two reads outstanding
    start(1'b0);
    for (int k = 0; k < 10 && ar_cnt < 2; k++) cyc(1);
    rv_en = 1'b0;
    for (int k = 0; k < 20 && AXI_ARVALID; k++) cyc(1);
    chk("s6_ar4", 64'(ar_cnt), 64'd4);
    chk("s6_ivalid_pre", INSTR_VALID, 1'b1);
    RST = 1'b1;
    #1;
    chk("s6_arvalid", AXI_ARVALID, 1'b0);
    chk("s6_rready", AXI_RREADY, 1'b0);
    chk("s6_ivalid", INSTR_VALID, 1'b0);
    chk("s6_ierr", INSTR_ERR, 1'b0);
    chk("s6_araddr", AXI_ARADDR, RPC);
    rv_en = 1'b1;
    cyc(2);
    pop_pc.delete(); pop_err.delete();
    RST = 1'b0; INSTR_READY = 1'b1;
    for (int k = 0; k < 10 && !AXI_ARVALID; k++) cyc(1);
    chk("s6_first_v", AXI_ARVALID, 1'b1);
    chk("s6_first_a", AXI_ARADDR, RPC);
    wait_pops(2, 30);
    chk("s6_first_pc", pop_pc[0], RPC);

    cyc(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
